// File: rtl/i2c_reset_sequencer_pkg.sv
// Shared definitions for the I2C reset sequencer.
//   seq_state_e : sequencer state encoding (3 bits)
//   DefCntW     : default width of the shared down-counter
package i2c_reset_sequencer_pkg;

    localparam int unsigned DefCntW = 8;

    typedef enum logic [2:0] {
        StCore     = 3'd0,
        StPeTail   = 3'd1,
        StRun      = 3'd2,
        StWaitIdle = 3'd3,
        StPePulse  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/i2c_reset_sequencer_if.sv
// Request/status bundle between the register interface and the reset sequencer.
//   master : register/board side, drives sw_rst_req, pe_rst_req, bus_idle
//   slave  : the sequencer, drives rst, pe_rst, ready, pe_timeout
interface i2c_reset_sequencer_if;

    logic sw_rst_req;
    logic pe_rst_req;
    logic bus_idle;
    logic rst;
    logic pe_rst;
    logic ready;
    logic pe_timeout;

    modport master (
        output sw_rst_req, pe_rst_req, bus_idle,
        input  rst, pe_rst, ready, pe_timeout
    );

    modport slave (
        input  sw_rst_req, pe_rst_req, bus_idle,
        output rst, pe_rst, ready, pe_timeout
    );

endinterface

// File: rtl/i2c_reset_sequencer_timer.sv
// Loadable down-counter shared by every timed state of the reset sequencer.
//   clk      : system clock
//   load     : load load_val (has priority over en)
//   load_val : reload value
//   en       : decrement by one
//   zero     : counter currently holds zero
module i2c_reset_sequencer_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // No reset of its own: the sequencer asserts load whenever rst_n is low.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_reset_sequencer.sv
// Generates the I2C block's active-high reset pair (rst for the core, pe_rst for the
// protocol engine) from board reset and software requests. PE-only resets wait for an
// idle bus, or are forced after IDLE_TIMEOUT cycles.
//   clk   : system clock
//   rst_n : board reset, synchronous, active-low
//   bus   : slave side of i2c_reset_sequencer_if (requests, bus_idle in; resets, ready,
//           pe_timeout out, all registered)
module i2c_reset_sequencer
    import i2c_reset_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W           = DefCntW,
    parameter int unsigned CORE_RST_CYCLES = 8,
    parameter int unsigned PE_RST_CYCLES   = 4,
    parameter int unsigned IDLE_TIMEOUT    = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    i2c_reset_sequencer_if.slave   bus
);

    // Reload with count-1 so the state lasts exactly count cycles and never wraps.
    localparam logic [CNT_W-1:0] CoreLoad = CNT_W'(CORE_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PeLoad   = CNT_W'(PE_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] IdleLoad = CNT_W'(IDLE_TIMEOUT - 1);

    seq_state_e       state_q;
    logic             rst_q, pe_rst_q, ready_q, pe_timeout_q;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    i2c_reset_sequencer_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Timer control mirrors the transitions taken by the state register below.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = CoreLoad;
        if (!rst_n || bus.sw_rst_req) begin
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                StCore: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = PeLoad;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                StPeTail, StPePulse: tmr_en = !tmr_zero;
                StRun: begin
                    if (bus.pe_rst_req) begin
                        tmr_load = 1'b1;
                        tmr_val  = IdleLoad;
                    end
                end
                StWaitIdle: begin
                    if (bus.bus_idle || tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = PeLoad;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: tmr_load = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StCore;
            rst_q        <= 1'b1;
            pe_rst_q     <= 1'b1;
            ready_q      <= 1'b0;
            pe_timeout_q <= 1'b0;
        end else begin
            pe_timeout_q <= 1'b0;
            if (bus.sw_rst_req) begin
                // Software reset wins over everything, including a pending PE request.
                state_q  <= StCore;
                rst_q    <= 1'b1;
                pe_rst_q <= 1'b1;
                ready_q  <= 1'b0;
            end else begin
                case (state_q)
                    StCore: begin
                        if (tmr_zero) begin
                            state_q <= StPeTail;
                            rst_q   <= 1'b0;
                        end
                    end
                    StPeTail, StPePulse: begin
                        if (tmr_zero) begin
                            state_q  <= StRun;
                            pe_rst_q <= 1'b0;
                            ready_q  <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (bus.pe_rst_req) begin
                            state_q <= StWaitIdle;
                            ready_q <= 1'b0;
                        end
                    end
                    StWaitIdle: begin
                        if (bus.bus_idle || tmr_zero) begin
                            state_q      <= StPePulse;
                            pe_rst_q     <= 1'b1;
                            pe_timeout_q <= !bus.bus_idle;
                        end
                    end
                    default: begin
                        state_q  <= StCore;
                        rst_q    <= 1'b1;
                        pe_rst_q <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rst        = rst_q;
    assign bus.pe_rst     = pe_rst_q;
    assign bus.ready      = ready_q;
    assign bus.pe_timeout = pe_timeout_q;

endmodule
